// File: rtl/rf_wr_arb_pkg.sv
// Shared types for the register-file write-port arbiter.
// Queue entry layout and grant encoding.
package rf_wr_arb_pkg;
  localparam int REG_W  = 3;
  localparam int DATA_W = 16;

  typedef enum logic [1:0] {
    GNT_IDLE,
    GNT_A,
    GNT_DRAIN
  } grant_e;

  typedef struct packed {
    logic [REG_W-1:0]  regsel;
    logic [DATA_W-1:0] data;
  } entry_t;
endpackage

// File: rtl/rf_wr_fifo.sv
// Small synchronous FIFO holding queued B writes.
// Exposes all slots plus a validity mask for pending-register lookups.
module rf_wr_fifo
  import rf_wr_arb_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      i_push,
  input  entry_t                    i_wentry,
  input  logic                      i_pop,
  output entry_t                    o_head,
  output logic [$clog2(DEPTH):0]    o_count,
  output entry_t [DEPTH-1:0]        o_entries,
  output logic   [DEPTH-1:0]        o_vld
);
  localparam int PW = $clog2(DEPTH);

  entry_t [DEPTH-1:0] r_mem;
  logic [PW-1:0]      r_head;
  logic [PW-1:0]      r_tail;
  logic [PW:0]        r_count;
  logic               w_full;
  logic               w_empty;
  logic               w_push;
  logic               w_pop;
  logic [PW-1:0]      w_off;

  assign w_full  = (r_count == (PW+1)'(DEPTH));
  assign w_empty = (r_count == '0);
  assign w_push  = i_push && !w_full;
  assign w_pop   = i_pop && !w_empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_tail] <= i_wentry;
        r_tail        <= r_tail + 1'b1;
      end
      if (w_pop) r_head <= r_head + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // A slot is live when its distance from head is below the count.
  always_comb begin
    o_vld = '0;
    w_off = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_off    = PW'(i) - r_head;
      o_vld[i] = ({1'b0, w_off} < r_count);
    end
  end

  assign o_head    = r_mem[r_head];
  assign o_count   = r_count;
  assign o_entries = r_mem;
endmodule

// File: rtl/rf_wr_arb.sv
// Shares the register-file write port between writeback (A)
// and a queued multi-cycle requester (B) with bounded starvation.
module rf_wr_arb
  import rf_wr_arb_pkg::*;
#(
  parameter int DEPTH      = 2,
  parameter int STARVE_MAX = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_wr,
  input  logic [REG_W-1:0]  a_regsel,
  input  logic [DATA_W-1:0] a_data,
  output logic              stall_a,
  input  logic              b_valid,
  input  logic [REG_W-1:0]  b_regsel,
  input  logic [DATA_W-1:0] b_data,
  output logic              b_ready,
  input  logic [REG_W-1:0]  read1regsel,
  input  logic [REG_W-1:0]  read2regsel,
  output logic              pend1,
  output logic              pend2,
  output logic              rf_write,
  output logic [REG_W-1:0]  rf_writeregsel,
  output logic [DATA_W-1:0] rf_writedata,
  output logic              err
);
  localparam int CW = $clog2(DEPTH) + 1;

  entry_t             w_head;
  entry_t [DEPTH-1:0] w_entries;
  logic   [DEPTH-1:0] w_vld;
  logic   [CW-1:0]    w_count;
  logic               w_empty;
  logic               w_push;
  grant_e             w_gnt;
  logic   [2:0]       r_starv;
  logic               r_bwait;

  assign w_empty = (w_count == '0);
  assign b_ready = (w_count < CW'(DEPTH));
  assign w_push  = b_valid && b_ready;
  assign stall_a = (r_starv == 3'(STARVE_MAX)) && !w_empty;

  rf_wr_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .i_push    (w_push),
    .i_wentry  ('{regsel: b_regsel, data: b_data}),
    .i_pop     (w_gnt == GNT_DRAIN),
    .o_head    (w_head),
    .o_count   (w_count),
    .o_entries (w_entries),
    .o_vld     (w_vld)
  );

  always_comb begin
    w_gnt = GNT_IDLE;
    unique case (1'b1)
      stall_a || (!a_wr && !w_empty): w_gnt = GNT_DRAIN;
      a_wr && !stall_a:               w_gnt = GNT_A;
      default:                        w_gnt = GNT_IDLE;
    endcase
  end

  always_comb begin
    rf_write       = 1'b0;
    rf_writeregsel = '0;
    rf_writedata   = '0;
    case (w_gnt)
      GNT_DRAIN: begin
        rf_write       = 1'b1;
        rf_writeregsel = w_head.regsel;
        rf_writedata   = w_head.data;
      end
      GNT_A: begin
        rf_write       = 1'b1;
        rf_writeregsel = a_regsel;
        rf_writedata   = a_data;
      end
      default: ;
    endcase
  end

  // The slot being drained this cycle still reports as pending.
  always_comb begin
    pend1 = 1'b0;
    pend2 = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      pend1 = pend1 | (w_vld[i] && w_entries[i].regsel == read1regsel);
      pend2 = pend2 | (w_vld[i] && w_entries[i].regsel == read2regsel);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_starv <= '0;
      r_bwait <= 1'b0;
    end else begin
      r_bwait <= b_valid && !b_ready;
      if (w_gnt == GNT_DRAIN || w_empty) r_starv <= '0;
      else if (w_gnt == GNT_A && r_starv != 3'(STARVE_MAX))
        r_starv <= r_starv + 3'd1;
    end
  end

  assign err = r_bwait && !b_valid;
endmodule

// File: tb/tb_rf_wr_arb.sv
// Directed bench for rf_wr_arb: vector table plus hand sequences
// for queue-full, protocol error and reset discard.
module tb_rf_wr_arb;
  logic        clk = 1'b0;
  logic        rst;
  logic        a_wr;
  logic [2:0]  a_regsel;
  logic [15:0] a_data;
  logic        stall_a;
  logic        b_valid;
  logic [2:0]  b_regsel;
  logic [15:0] b_data;
  logic        b_ready;
  logic [2:0]  read1regsel;
  logic [2:0]  read2regsel;
  logic        pend1;
  logic        pend2;
  logic        rf_write;
  logic [2:0]  rf_writeregsel;
  logic [15:0] rf_writedata;
  logic        err;

  int n_pass = 0;
  int n_tot  = 0;

  always #5 clk = ~clk;

  rf_wr_arb #(.DEPTH(2), .STARVE_MAX(3)) dut (
    .clk            (clk),
    .rst            (rst),
    .a_wr           (a_wr),
    .a_regsel       (a_regsel),
    .a_data         (a_data),
    .stall_a        (stall_a),
    .b_valid        (b_valid),
    .b_regsel       (b_regsel),
    .b_data         (b_data),
    .b_ready        (b_ready),
    .read1regsel    (read1regsel),
    .read2regsel    (read2regsel),
    .pend1          (pend1),
    .pend2          (pend2),
    .rf_write       (rf_write),
    .rf_writeregsel (rf_writeregsel),
    .rf_writedata   (rf_writedata),
    .err            (err)
  );

  typedef struct {
    logic        aw;
    logic [2:0]  ars;
    logic [15:0] ad;
    logic        bv;
    logic [2:0]  brs;
    logic [15:0] bd;
    logic [2:0]  r1;
    logic [2:0]  r2;
    logic        wr;
    logic [2:0]  ws;
    logic [15:0] wd;
    logic        brdy;
    logic        st;
    logic        p1;
    logic        p2;
    logic        er;
  } vec_t;

  vec_t vt[11];

  task automatic chk(input string nm, input logic [15:0] act,
                     input logic [15:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", nm, act, exp);
  endtask

  task automatic drv(input logic aw, input logic [15:0] ad,
                     input logic bv, input logic [2:0] brs,
                     input logic [15:0] bd);
    @(posedge clk);
    #1;
    a_wr     = aw;
    a_regsel = 3'd1;
    a_data   = ad;
    b_valid  = bv;
    b_regsel = brs;
    b_data   = bd;
    #3;
  endtask

  task automatic chk_rf(input string nm, input logic wr,
                        input logic [2:0] ws, input logic [15:0] wd);
    chk({nm, ".wr"}, 16'(rf_write), 16'(wr));
    chk({nm, ".ws"}, 16'(rf_writeregsel), 16'(ws));
    chk({nm, ".wd"}, rf_writedata, wd);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: got running want finished");
    $fatal(1, "timeout");
  end

  initial begin
    // aw ars ad  bv brs bd  r1 r2 | wr ws wd  brdy st p1 p2 er
    vt[0]  = '{0,0,16'h0000, 0,0,16'h0000, 0,0, 0,0,16'h0000, 1,0,0,0,0};
    vt[1]  = '{1,5,16'hBEEF, 0,0,16'h0000, 5,0, 1,5,16'hBEEF, 1,0,0,0,0};
    vt[2]  = '{0,0,16'h0000, 1,2,16'h1234, 2,0, 0,0,16'h0000, 1,0,0,0,0};
    vt[3]  = '{0,0,16'h0000, 0,0,16'h0000, 2,3, 1,2,16'h1234, 1,0,1,0,0};
    vt[4]  = '{0,0,16'h0000, 0,0,16'h0000, 2,3, 0,0,16'h0000, 1,0,0,0,0};
    vt[5]  = '{1,1,16'h0001, 1,6,16'h00AA, 0,6, 1,1,16'h0001, 1,0,0,0,0};
    vt[6]  = '{1,1,16'h0002, 0,0,16'h0000, 0,6, 1,1,16'h0002, 1,0,0,1,0};
    vt[7]  = '{1,1,16'h0003, 0,0,16'h0000, 0,6, 1,1,16'h0003, 1,0,0,1,0};
    vt[8]  = '{1,1,16'h0004, 0,0,16'h0000, 0,6, 1,1,16'h0004, 1,0,0,1,0};
    vt[9]  = '{1,1,16'h0005, 0,0,16'h0000, 0,6, 1,6,16'h00AA, 1,1,0,1,0};
    vt[10] = '{1,1,16'h0005, 0,0,16'h0000, 0,6, 1,1,16'h0005, 1,0,0,0,0};

    rst = 1'b1;
    a_wr = 0; a_regsel = 0; a_data = 0;
    b_valid = 0; b_regsel = 0; b_data = 0;
    read1regsel = 0; read2regsel = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    for (int i = 0; i < 11; i++) begin
      @(posedge clk);
      #1;
      a_wr        = vt[i].aw;
      a_regsel    = vt[i].ars;
      a_data      = vt[i].ad;
      b_valid     = vt[i].bv;
      b_regsel    = vt[i].brs;
      b_data      = vt[i].bd;
      read1regsel = vt[i].r1;
      read2regsel = vt[i].r2;
      #3;
      chk_rf($sformatf("v%0d", i), vt[i].wr, vt[i].ws, vt[i].wd);
      chk($sformatf("v%0d.brdy", i), 16'(b_ready), 16'(vt[i].brdy));
      chk($sformatf("v%0d.stall", i), 16'(stall_a), 16'(vt[i].st));
      chk($sformatf("v%0d.p1", i), 16'(pend1), 16'(vt[i].p1));
      chk($sformatf("v%0d.p2", i), 16'(pend2), 16'(vt[i].p2));
      chk($sformatf("v%0d.err", i), 16'(err), 16'(vt[i].er));
    end

    // Fill the queue under continuous A, then a withdrawn B request.
    read1regsel = 3'd3;
    read2regsel = 3'd4;
    drv(1, 16'h0010, 1, 3'd3, 16'h00A1);
    chk("f1.brdy", 16'(b_ready), 16'd1);
    chk_rf("f1", 1, 3'd1, 16'h0010);
    drv(1, 16'h0011, 1, 3'd4, 16'h00A2);
    chk("f2.brdy", 16'(b_ready), 16'd1);
    chk("f2.p1", 16'(pend1), 16'd1);
    drv(1, 16'h0012, 1, 3'd7, 16'h00A3);
    chk("f3.brdy", 16'(b_ready), 16'd0);
    chk("f3.p2", 16'(pend2), 16'd1);
    chk_rf("f3", 1, 3'd1, 16'h0012);
    drv(1, 16'h0013, 0, 3'd0, 16'h0000);
    chk("f4.err", 16'(err), 16'd1);
    chk("f4.stall", 16'(stall_a), 16'd0);
    drv(1, 16'h0014, 0, 3'd0, 16'h0000);
    chk("f5.err", 16'(err), 16'd0);
    chk("f5.stall", 16'(stall_a), 16'd1);
    chk("f5.brdy", 16'(b_ready), 16'd0);
    chk_rf("f5", 1, 3'd3, 16'h00A1);
    drv(1, 16'h0014, 0, 3'd0, 16'h0000);
    chk("f6.brdy", 16'(b_ready), 16'd1);
    chk("f6.stall", 16'(stall_a), 16'd0);
    chk("f6.p1", 16'(pend1), 16'd0);
    chk_rf("f6", 1, 3'd1, 16'h0014);
    drv(1, 16'h0015, 0, 3'd0, 16'h0000);
    chk_rf("f7", 1, 3'd1, 16'h0015);
    drv(1, 16'h0016, 0, 3'd0, 16'h0000);
    chk_rf("f8", 1, 3'd1, 16'h0016);
    drv(1, 16'h0017, 0, 3'd0, 16'h0000);
    chk("f9.stall", 16'(stall_a), 16'd1);
    chk_rf("f9", 1, 3'd4, 16'h00A2);
    drv(0, 16'h0000, 0, 3'd0, 16'h0000);
    chk_rf("f10", 0, 3'd0, 16'h0000);
    chk("f10.p2", 16'(pend2), 16'd0);

    // Reset with two queued entries discards them.
    drv(1, 16'h0020, 1, 3'd3, 16'h00B1);
    drv(1, 16'h0021, 1, 3'd4, 16'h00B2);
    chk("r0.brdy", 16'(b_ready), 16'd1);
    @(posedge clk);
    #1;
    rst = 1'b1; a_wr = 0; b_valid = 0;
    @(posedge clk);
    #1 rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      drv(0, 16'h0000, 0, 3'd0, 16'h0000);
      chk($sformatf("r%0d.wr", k + 1), 16'(rf_write), 16'd0);
      chk($sformatf("r%0d.p1", k + 1), 16'(pend1), 16'd0);
      chk($sformatf("r%0d.p2", k + 1), 16'(pend2), 16'd0);
      chk($sformatf("r%0d.brdy", k + 1), 16'(b_ready), 16'd1);
      chk($sformatf("r%0d.stall", k + 1), 16'(stall_a), 16'd0);
      chk($sformatf("r%0d.err", k + 1), 16'(err), 16'd0);
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
